conv_sched: RTL and testbench
=============================

Name: conv_sched

Overview:
- Sequencing controller for the 2D convolution engine.
- Walks output window origins and kernel taps in raster order.
- Issues input-memory read addresses and accumulator strobes (accumulate enable, clear, kernel tap index), then one output-memory write per window.
- Sits between the configuration/start logic and the conv datapath and input/output memories; owns the start/done handshake.

Parameters:
- AW, 16, input/output memory address width.
- DIMW, 8, width of dimension, stop, stride and kernel-size fields.
- KIW, 8, width of kernel tap index k_idx.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- start  in  1  begin job; sampled only in IDLE
- cfg_di_w  in  DIMW  input image width
- cfg_di_h  in  DIMW  input image height
- cfg_x_stop  in  DIMW  last allowed window origin x (inclusive)
- cfg_y_stop  in  DIMW  last allowed window origin y (inclusive)
- cfg_stride_x  in  DIMW  horizontal stride
- cfg_stride_y  in  DIMW  vertical stride
- cfg_k_w  in  DIMW  kernel width
- cfg_k_h  in  DIMW  kernel height
- cfg_base_in  in  AW  input buffer base address
- cfg_base_out  in  AW  output buffer base address
- mi_rd  out  1  input read request
- mi_addr  out  AW  input read address
- mi_ready  in  1  input memory accepts request this cycle
- acc_en  out  1  read data valid at datapath; accumulate
- acc_clr  out  1  with acc_en: load instead of add (first tap)
- k_idx  out  KIW  kernel tap index aligned with acc_en
- mo_wr  out  1  output write strobe
- mo_addr  out  AW  output write address
- busy  out  1  job in progress
- done  out  1  one-cycle end-of-job pulse
- err  out  1  one-cycle pulse with done on bad config

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset may assert mid-job: the controller returns to IDLE immediately, with no done pulse.
- cfg_* are latched on the start-accept edge. Later changes are ignored until the next job.
- start while busy is ignored.

States:
- IDLE: on start, latch config, assert busy, go to CHECK.
- CHECK (1 cycle): error if any of the following holds: k_w==0, k_h==0, stride_x==0, stride_y==0, x_stop+k_w>di_w, y_stop+k_h>di_h. Error goes to DONE with err. Otherwise origin (ox,oy)=(0,0), tap (kx,ky)=(0,0), go to TAP.
- TAP: mi_rd=1, mi_addr=base_in+(oy+ky)*di_w+(ox+kx). The request is held stable until mi_ready. Each accepted request advances kx, wrapping into ky. After the accept of tap (k_w-1,k_h-1), go to DRAIN.
- DRAIN (1 cycle): no request; the last acc_en is issued here.
- WRITE (1 cycle): mo_wr=1, mo_addr=base_out+n, where n is the window count from 0. Then advance ox+=stride_x. If ox>x_stop, set ox=0 and oy+=stride_y. If oy>y_stop, go to DONE; else go to TAP.
- DONE (1 cycle): done=1, err as determined in CHECK, busy=0 next cycle, go to IDLE.

Timing and arithmetic:
- Read latency is fixed at 1 cycle: acc_en, acc_clr and k_idx assert the cycle after each accepted request.
- acc_clr=1 only for tap (0,0). k_idx=ky*k_w+kx.
- Addresses use incremental adders only (no multipliers): a row pointer advances by di_w, a column offset by 1.
- Address arithmetic wraps modulo 2^AW.
- Stop comparisons use DIMW+1-bit sums so they cannot overflow.
- Windows do not overlap. With no stalls, each window takes k_w*k_h+2 cycles.

Optional Feature:
Macro CONV_SCHED_PERF_EN.
- Defined: adds outputs perf_cycles[31:0] (busy cycles) and perf_stalls[31:0] (cycles with mi_rd && !mi_ready). Both clear on start accept, saturate at all-ones, and hold after done.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- di_w=6, di_h=8, x_stop=3, y_stop=5, stride 1/1, k 3x3, bases 0, mi_ready=1 -> window 0 addresses 0,1,2,6,7,8,12,13,14; 24 mo_wr at mo_addr 0..23; 216 acc_en, 24 with acc_clr. done occurs 266 cycles after the start edge, err=0.
- Same config with stride 2/2 -> origins (0,0),(2,0),(0,2),(2,2),(0,4),(2,4). Window 3 first address 14. 6 writes.
- mi_ready low 3 cycles during tap 4 of window 0 -> mi_addr held at 7; no acc_en while stalled; total 269 cycles. Under CONV_SCHED_PERF_EN: perf_stalls=3.
- k_w=7 with di_w=6 -> no mi_rd or mo_wr; done and err pulse together 2 cycles after start.
- Reset asserted mid-TAP in window 5 -> all outputs 0, IDLE. A subsequent start runs a full clean job.
- start pulsed again while busy, and cfg_di_w changed mid-job -> no effect; addresses match the first scenario.

Source files
------------

// File: rtl/conv_sched.sv
// conv_sched: raster walker over conv windows/taps driving input reads, accumulator strobes and output writes.
// Optional perf counters (perf_cycles, perf_stalls) are built when CONV_SCHED_PERF_EN is defined.
module conv_sched #(
    parameter int AW   = 16,
    parameter int DIMW = 8,
    parameter int KIW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DIMW-1:0] cfg_di_w,
    input  logic [DIMW-1:0] cfg_di_h,
    input  logic [DIMW-1:0] cfg_x_stop,
    input  logic [DIMW-1:0] cfg_y_stop,
    input  logic [DIMW-1:0] cfg_stride_x,
    input  logic [DIMW-1:0] cfg_stride_y,
    input  logic [DIMW-1:0] cfg_k_w,
    input  logic [DIMW-1:0] cfg_k_h,
    input  logic [AW-1:0]   cfg_base_in,
    input  logic [AW-1:0]   cfg_base_out,
    output logic            mi_rd,
    output logic [AW-1:0]   mi_addr,
    input  logic            mi_ready,
    output logic            acc_en,
    output logic            acc_clr,
    output logic [KIW-1:0]  k_idx,
    output logic            mo_wr,
    output logic [AW-1:0]   mo_addr,
    output logic            busy,
    output logic            done,
    output logic            err
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_stalls
`endif
);
    typedef enum logic [2:0] {IDLE, CHECK, TAP, DRAIN, WRITE, DONE} state_e;
    localparam int BPC = (DIMW + 2) / 3;
    state_e state_q, state_d;
    logic [DIMW-1:0] di_w_q, di_h_q, xs_q, ys_q, sx_q, sy_q, kw_q, kh_q;
    logic [DIMW-1:0] ox_q, oy_q, kx_q, ky_q, sym_q;
    logic [AW-1:0]   bin_q, bout_q, orow_q, org_q, trow_q, n_q, rstep_q, mc_q;
    logic [KIW-1:0]  kidx_q, k_idx_q;
    logic            err_q, acc_en_q, acc_clr_q;
    logic            accept, last_kx, last_ky, cfg_bad, row_wrap, y_end;
    logic [DIMW:0]   ox_nx, oy_nx;
    logic [AW-1:0]   step_add, orow_nx, org_nx;
    assign cfg_bad = kw_q == '0 || kh_q == '0 || sx_q == '0 || sy_q == '0
                   || {1'b0, xs_q} + {1'b0, kw_q} > {1'b0, di_w_q}
                   || {1'b0, ys_q} + {1'b0, kh_q} > {1'b0, di_h_q};
    assign accept   = state_q == TAP && mi_ready;
    assign last_kx  = kx_q == kw_q - 1'b1;
    assign last_ky  = ky_q == kh_q - 1'b1;
    assign ox_nx    = {1'b0, ox_q} + {1'b0, sx_q};
    assign oy_nx    = {1'b0, oy_q} + {1'b0, sy_q};
    assign row_wrap = ox_nx > {1'b0, xs_q};
    assign y_end    = row_wrap && oy_nx > {1'b0, ys_q};
    assign orow_nx  = row_wrap ? orow_q + rstep_q : orow_q;
    assign org_nx   = row_wrap ? orow_nx : org_q + AW'(sx_q);
    // stride_y*di_w is built a few bits per cycle; three edges (CHECK, TAP, DRAIN) always precede the first WRITE
    always_comb begin
        step_add = '0;
        for (int j = 0; j < BPC; j++)
            step_add = step_add + (sym_q[j] ? mc_q << j : '0);
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? CHECK : IDLE;
            CHECK:   state_d = cfg_bad ? DONE : TAP;
            TAP:     state_d = (accept && last_kx && last_ky) ? DRAIN : TAP;
            DRAIN:   state_d = WRITE;
            WRITE:   state_d = y_end ? DONE : TAP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            {di_w_q, di_h_q, xs_q, ys_q, sx_q, sy_q, kw_q, kh_q} <= '0;
            {ox_q, oy_q, kx_q, ky_q, sym_q} <= '0;
            {bin_q, bout_q, orow_q, org_q, trow_q, n_q, rstep_q, mc_q} <= '0;
            {kidx_q, k_idx_q, err_q, acc_en_q, acc_clr_q} <= '0;
        end else begin
            acc_en_q  <= accept;
            acc_clr_q <= accept && kidx_q == '0;
            k_idx_q   <= kidx_q;
            rstep_q   <= rstep_q + step_add;
            sym_q     <= sym_q >> BPC;
            mc_q      <= mc_q << BPC;
            if (state_q == IDLE && start) begin
                {di_w_q, di_h_q, xs_q, ys_q} <= {cfg_di_w, cfg_di_h, cfg_x_stop, cfg_y_stop};
                {sx_q, sy_q, kw_q, kh_q}     <= {cfg_stride_x, cfg_stride_y, cfg_k_w, cfg_k_h};
                {bin_q, bout_q}              <= {cfg_base_in, cfg_base_out};
                sym_q   <= cfg_stride_y;
                mc_q    <= AW'(cfg_di_w);
                rstep_q <= '0;
            end
            if (state_q == CHECK) begin
                err_q <= cfg_bad;
                {ox_q, oy_q, kx_q, ky_q, kidx_q, n_q} <= '0;
                {orow_q, org_q, trow_q} <= {bin_q, bin_q, bin_q};
            end
            if (accept) begin
                kidx_q <= kidx_q + 1'b1;
                kx_q   <= last_kx ? '0 : kx_q + 1'b1;
                if (last_kx) begin
                    ky_q   <= last_ky ? '0 : ky_q + 1'b1;
                    trow_q <= trow_q + AW'(di_w_q);
                end
            end
            if (state_q == WRITE) begin
                n_q    <= n_q + 1'b1;
                kidx_q <= '0;
                ox_q   <= row_wrap ? '0 : ox_nx[DIMW-1:0];
                oy_q   <= row_wrap ? oy_nx[DIMW-1:0] : oy_q;
                orow_q <= orow_nx;
                org_q  <= org_nx;
                trow_q <= org_nx;
            end
        end
    end
    assign mi_rd   = state_q == TAP;
    assign mi_addr = trow_q + AW'(kx_q);
    assign acc_en  = acc_en_q;
    assign acc_clr = acc_clr_q;
    assign k_idx   = k_idx_q;
    assign mo_wr   = state_q == WRITE;
    assign mo_addr = bout_q + n_q;
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign err     = done && err_q;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] pc_q, ps_q;
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q <= '0;
            ps_q <= '0;
        end else if (state_q == IDLE && start) begin
            pc_q <= '0;
            ps_q <= '0;
        end else begin
            pc_q <= (busy && ~&pc_q) ? pc_q + 1'b1 : pc_q;
            ps_q <= (mi_rd && !mi_ready && ~&ps_q) ? ps_q + 1'b1 : ps_q;
        end
    end
    assign perf_cycles = pc_q;
    assign perf_stalls = ps_q;
`endif
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: table-driven and randomized checks of conv_sched against a loop-nest reference model.
module tb_conv_sched;
    logic clk = 0, rst_n = 1, start = 0, mi_ready = 1;
    logic [7:0] cfg_di_w = 0, cfg_di_h = 0, cfg_x_stop = 0, cfg_y_stop = 0;
    logic [7:0] cfg_stride_x = 0, cfg_stride_y = 0, cfg_k_w = 0, cfg_k_h = 0;
    logic [15:0] cfg_base_in = 0, cfg_base_out = 0;
    logic mi_rd, acc_en, acc_clr, mo_wr, busy, done, err;
    logic [15:0] mi_addr, mo_addr;
    logic [7:0] k_idx;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif
    always #5 clk = ~clk;
    conv_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_di_w(cfg_di_w), .cfg_di_h(cfg_di_h), .cfg_x_stop(cfg_x_stop), .cfg_y_stop(cfg_y_stop),
        .cfg_stride_x(cfg_stride_x), .cfg_stride_y(cfg_stride_y), .cfg_k_w(cfg_k_w), .cfg_k_h(cfg_k_h),
        .cfg_base_in(cfg_base_in), .cfg_base_out(cfg_base_out),
        .mi_rd(mi_rd), .mi_addr(mi_addr), .mi_ready(mi_ready),
        .acc_en(acc_en), .acc_clr(acc_clr), .k_idx(k_idx),
        .mo_wr(mo_wr), .mo_addr(mo_addr), .busy(busy), .done(done), .err(err)
`ifdef CONV_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );
    typedef struct { int di_w, di_h, xs, ys, sx, sy, kw, kh, bin, bout; } cfg_t;
    typedef struct { cfg_t c; int stall_tap, stall_len, wr, acc, clr, lat, err; } vec_t;
    int checks = 0, errors = 0;
    int rd_q[$], kid_q[$], clr_q[$], wr_q[$];
    int e_rd[$], e_kid[$], e_clr[$], e_wr[$];
    int lat, got_err, stalls, align_bad, hold_bad, post_bad, stall_addr;
    bit rst_hit;
    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    function automatic int qdiff(input int a[$], input int b[$]);
        int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] != b[i]) d++;
        return d;
    endfunction
    function automatic int qsum(input int a[$]);
        int s = 0;
        foreach (a[i]) s += a[i];
        return s;
    endfunction
    // reference: plain loop nest over origins and taps, straight from the addressing formula
    task automatic model(input cfg_t c, output int e_err);
        int n = 0;
        e_rd.delete(); e_kid.delete(); e_clr.delete(); e_wr.delete();
        e_err = (c.kw == 0 || c.kh == 0 || c.sx == 0 || c.sy == 0 ||
                 c.xs + c.kw > c.di_w || c.ys + c.kh > c.di_h) ? 1 : 0;
        if (e_err == 0)
            for (int oy = 0; oy <= c.ys; oy += c.sy)
                for (int ox = 0; ox <= c.xs; ox += c.sx) begin
                    for (int ky = 0; ky < c.kh; ky++)
                        for (int kx = 0; kx < c.kw; kx++) begin
                            e_rd.push_back((c.bin + (oy + ky) * c.di_w + ox + kx) & 32'hFFFF);
                            e_kid.push_back((ky * c.kw + kx) & 32'hFF);
                            e_clr.push_back((kx == 0 && ky == 0) ? 1 : 0);
                        end
                    e_wr.push_back((c.bout + n) & 32'hFFFF);
                    n++;
                end
    endtask
    task automatic run_job(input cfg_t c, input int stall_tap, input int stall_len,
                           input bit rnd, input bit poke, input int rst_win);
        int sl = stall_len;
        bit prev_acc = 0, prev_stall = 0;
        logic [15:0] prev_addr = 0;
        rd_q.delete(); kid_q.delete(); clr_q.delete(); wr_q.delete();
        lat = 0; got_err = 0; stalls = 0; align_bad = 0; hold_bad = 0; post_bad = 0;
        stall_addr = -1; rst_hit = 0;
        @(posedge clk); #1;
        cfg_di_w = 8'(c.di_w); cfg_di_h = 8'(c.di_h); cfg_x_stop = 8'(c.xs); cfg_y_stop = 8'(c.ys);
        cfg_stride_x = 8'(c.sx); cfg_stride_y = 8'(c.sy); cfg_k_w = 8'(c.kw); cfg_k_h = 8'(c.kh);
        cfg_base_in = 16'(c.bin); cfg_base_out = 16'(c.bout);
        start = 1; mi_ready = 1;
        @(posedge clk); #1;
        start = 0;
        {cfg_di_w, cfg_di_h, cfg_x_stop, cfg_y_stop} = $urandom;
        {cfg_stride_x, cfg_stride_y, cfg_k_w, cfg_k_h} = $urandom;
        {cfg_base_in, cfg_base_out} = $urandom;
        for (int n = 1; n <= 20000 && lat == 0 && !rst_hit; n++) begin
            if (rst_win >= 0 && wr_q.size() == rst_win && mi_rd) begin
                rst_n = 1;
                @(negedge clk);
                chk("rst_outputs", int'(|{mi_rd, mi_addr, acc_en, acc_clr, k_idx, mo_wr, mo_addr, busy, done, err}), 0);
                @(posedge clk); #1;
                rst_n = 0;
                rst_hit = 1;
            end else begin
                mi_ready = rnd ? ($urandom_range(0, 3) != 0) : !(mi_rd && rd_q.size() == stall_tap && sl > 0);
                if (!rnd && !mi_ready) sl--;
                if (poke) start = (n == 40);
                if (poke && n == 40) cfg_di_w = 8'd9;
                @(negedge clk);
                if (acc_en != prev_acc) align_bad++;
                if (acc_en) begin
                    kid_q.push_back(int'(k_idx));
                    clr_q.push_back(int'(acc_clr));
                end
                if (prev_stall && mi_addr != prev_addr) hold_bad++;
                prev_stall = mi_rd && !mi_ready;
                prev_addr = mi_addr;
                if (prev_stall) begin
                    stalls++;
                    stall_addr = int'(mi_addr);
                end
                prev_acc = mi_rd && mi_ready;
                if (mi_rd && mi_ready) rd_q.push_back(int'(mi_addr));
                if (mo_wr) wr_q.push_back(int'(mo_addr));
                if (done) begin
                    lat = n;
                    got_err = int'(err);
                end
                @(posedge clk); #1;
            end
        end
        start = 0; mi_ready = 1;
        if (lat > 0) begin
            @(negedge clk);
            post_bad = int'(done || busy);
        end
    endtask
    task automatic check_job(input string tag, input cfg_t c);
        int e_err, e_lat;
        model(c, e_err);
        e_lat = e_err ? 2 : 2 + e_wr.size() * (c.kw * c.kh + 2) + stalls;
        chk({tag, ".rd_seq"}, qdiff(rd_q, e_rd), 0);
        chk({tag, ".kidx_seq"}, qdiff(kid_q, e_kid), 0);
        chk({tag, ".clr_seq"}, qdiff(clr_q, e_clr), 0);
        chk({tag, ".wr_seq"}, qdiff(wr_q, e_wr), 0);
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".err"}, got_err, e_err);
        chk({tag, ".acc_align"}, align_bad, 0);
        chk({tag, ".stall_hold"}, hold_bad, 0);
        chk({tag, ".post_done"}, post_bad, 0);
`ifdef CONV_SCHED_PERF_EN
        chk({tag, ".perf_cycles"}, perf_cycles, e_lat);
        chk({tag, ".perf_stalls"}, perf_stalls, stalls);
`endif
    endtask
    initial begin
        vec_t vt[10];
        int w0[9];
        cfg_t c;
        vt[0] = '{'{6, 8, 3, 5, 1, 1, 3, 3, 0, 0}, -1, 0, 24, 216, 24, 266, 0};
        vt[1] = '{'{6, 8, 3, 5, 2, 2, 3, 3, 0, 0}, -1, 0, 6, 54, 6, 68, 0};
        vt[2] = '{'{6, 8, 3, 5, 1, 1, 3, 3, 0, 0}, 4, 3, 24, 216, 24, 269, 0};
        vt[3] = '{'{6, 8, 3, 5, 1, 1, 7, 3, 0, 0}, -1, 0, 0, 0, 0, 2, 1};
        vt[4] = '{'{6, 8, 3, 5, 0, 1, 3, 3, 0, 0}, -1, 0, 0, 0, 0, 2, 1};
        vt[5] = '{'{255, 8, 250, 5, 1, 1, 10, 3, 0, 0}, -1, 0, 0, 0, 0, 2, 1};
        vt[6] = '{'{6, 8, 3, 5, 1, 1, 3, 0, 0, 0}, -1, 0, 0, 0, 0, 2, 1};
        vt[7] = '{'{6, 7, 3, 5, 1, 1, 3, 3, 0, 0}, -1, 0, 0, 0, 0, 2, 1};
        vt[8] = '{'{4, 4, 1, 1, 1, 1, 3, 3, 'hFFF8, 'hFFFE}, -1, 0, 4, 36, 4, 46, 0};
        vt[9] = '{'{3, 250, 0, 249, 1, 200, 1, 1, 5, 0}, -1, 0, 2, 2, 2, 8, 0};
        w0 = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'(|{mi_rd, mi_addr, acc_en, acc_clr, k_idx, mo_wr, mo_addr, busy, done, err}), 0);
        @(posedge clk); #1;
        rst_n = 0;
        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            run_job(vt[i].c, vt[i].stall_tap, vt[i].stall_len, 0, 0, -1);
            check_job(t, vt[i].c);
            chk({t, ".writes"}, wr_q.size(), vt[i].wr);
            chk({t, ".accs"}, kid_q.size(), vt[i].acc);
            chk({t, ".clrs"}, qsum(clr_q), vt[i].clr);
            chk({t, ".lat_const"}, lat, vt[i].lat);
            chk({t, ".err_const"}, got_err, vt[i].err);
            if (i == 0) begin
                int d = 0;
                for (int k = 0; k < 9; k++) d += (k < rd_q.size() && rd_q[k] == w0[k]) ? 0 : 1;
                chk("win0_addrs", d, 0);
            end
            if (i == 1) chk("win3_first_addr", rd_q.size() > 27 ? rd_q[27] : -1, 14);
            if (i == 2) begin
                chk("stall_addr", stall_addr, 7);
                chk("stall_cycles", stalls, 3);
            end
        end
        run_job(vt[0].c, -1, 0, 0, 0, 5);
        chk("reset_mid_job_hit", rst_hit, 1);
        run_job(vt[0].c, -1, 0, 0, 0, -1);
        check_job("after_reset", vt[0].c);
        chk("after_reset.lat_const", lat, 266);
        run_job(vt[0].c, -1, 0, 0, 1, -1);
        check_job("start_while_busy", vt[0].c);
        chk("start_while_busy.lat_const", lat, 266);
        for (int r = 0; r < 20; r++) begin
            c.di_w = $urandom_range(1, 9);
            c.di_h = $urandom_range(1, 9);
            c.kw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            c.kh = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            c.sx = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            c.sy = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            c.xs = $urandom_range(0, c.di_w);
            c.ys = $urandom_range(0, c.di_h);
            c.bin = $urandom_range(0, 65535);
            c.bout = $urandom_range(0, 65535);
            run_job(c, -1, 0, 1, 0, -1);
            check_job($sformatf("rand%0d", r), c);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
